// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the processor core.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/data_ram.sv
// 256 x 8 data memory: combinational read at DataSrcA, synchronous write of DataSrcA to DataSrcB.
// Flop-based so that a synchronous reset can clear every word.
module data_ram
    import cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] DataSrcA,
    input  logic [ADDR_W-1:0] DataSrcB,
    output logic [DATA_W-1:0] DataMemOut
);

    // Name is relied upon by benches that preload contents hierarchically.
    word_t data_memory [DEPTH];

    // Reset wins over a coincident write.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_memory[i] <= '0;
            end
        end else if (MemWrite) begin
            data_memory[DataSrcB] <= DataSrcA;
        end
    end

    always_comb begin
        DataMemOut = '0;
        if (MemRead) begin
            DataMemOut = data_memory[DataSrcA];
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: reference memory model plus an expected-value queue.
module tb_data_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;

    logic [7:0] model [256];
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    data_ram dut (
        .CLK        (clk),
        .Reset      (rst),
        .MemRead    (rd),
        .MemWrite   (wr),
        .DataSrcA   (a),
        .DataSrcB   (b),
        .DataMemOut (out)
    );

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b1;
        rd  = 1'b0;
        a   = data;
        b   = addr;
        @(posedge clk);
        #1;
        wr  = 1'b0;
        model[addr] = data;
    endtask

    // Words 0..9 loaded, then each read back in the same cycle it is addressed.
    task automatic test_preload_read();
        for (int i = 0; i < 10; i++) do_write(8'(i), 8'(8'h30 + i));
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rd = 1'b1;
            a  = 8'(i);
            exp_q.push_back(model[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL preload_read addr=%0d got %h expected %h", i, out, e);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(8'h03, 8'h01);
        @(negedge clk);
        rd = 1'b1;
        a  = 8'h03;
        exp_q.push_back(8'h01);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL write_read got %h expected %h", out, e);
        end
    endtask

    task automatic test_read_disable();
        logic [7:0] addrs [4];
        addrs[0] = 8'h00; addrs[1] = 8'h01; addrs[2] = 8'h03; addrs[3] = 8'h09;
        @(negedge clk);
        rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = addrs[i];
            exp_q.push_back(8'h00);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL read_disable addr=%h got %h expected %h", addrs[i], out, e);
            end
        end
    endtask

    task automatic test_write_disable();
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'(i + 2);
            @(negedge clk);
        end
        for (int i = 2; i < 6; i++) begin
            rd = 1'b1;
            a  = 8'(i);
            exp_q.push_back(model[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL write_disable addr=%0d got %h expected %h", i, out, e);
            end
        end
    endtask

    // Reset coincident with a write: write must be dropped, every word cleared.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        wr  = 1'b1;
        rd  = 1'b0;
        b   = 8'h05;
        a   = 8'hAA;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        checks++;
        if (dut.data_memory[5] !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr5 got %h expected 00", dut.data_memory[5]);
        end
        rd = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            exp_q.push_back(model[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL reset_word addr=%0d got %h expected %h", i, out, e);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] addrs [4];
        do_write(8'hFF, 8'h5A);
        do_write(8'h00, 8'hA5);
        addrs[0] = 8'hFF; addrs[1] = 8'h00; addrs[2] = 8'hFE; addrs[3] = 8'h01;
        @(negedge clk);
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = addrs[i];
            exp_q.push_back(model[addrs[i]]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL boundary addr=%h got %h expected %h", addrs[i], out, e);
            end
        end
    endtask

    // Same address read and written: old value before the edge, new value after.
    task automatic test_read_during_write();
        do_write(8'h07, 8'h11);
        @(negedge clk);
        rd = 1'b1;
        wr = 1'b1;
        a  = 8'h07;
        b  = 8'h07;
        exp_q.push_back(model[7]);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL rdw_before got %h expected %h", out, e);
        end
        @(posedge clk);
        model[7] = 8'h07;
        exp_q.push_back(model[7]);
        #1;
        wr = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL rdw_after got %h expected %h", out, e);
        end
    endtask

    initial begin
        rst = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        test_preload_read();
        test_write_read();
        test_read_disable();
        test_write_disable();
        test_reset();
        test_boundaries();
        test_read_during_write();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached without completion");
        $fatal(1, "watchdog");
    end

endmodule
